// File: rtl/align_pkg.sv
// Shared constants and FSM encoding for the lane packer/unpacker pair.
package align_pkg;

   localparam int unsigned IDATA_BIT = 8;
   localparam int unsigned GBUS_DATA = 64;
   localparam int unsigned REG_NUM   = GBUS_DATA / IDATA_BIT;
   localparam int unsigned LANE_BIT  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY      = 2'd1,
      BUSY_PEND = 2'd2
   } align_state_t;

endpackage

// File: rtl/p2s_lane_sel.sv
// Priority encoder: lowest enabled lane, its one-hot clear mask, and whether it is the only one left.
module p2s_lane_sel
   import align_pkg::*;
(
   input  logic [REG_NUM-1:0]  mask,
   output logic [LANE_BIT-1:0] idx,
   output logic [REG_NUM-1:0]  clr,
   output logic                is_last
);

   logic found;

   always_comb begin
      idx     = '0;
      clr     = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < REG_NUM; i++) begin
         if (mask[i] && !found) begin
            idx    = LANE_BIT'(i);
            clr[i] = 1'b1;
            found  = 1'b1;
         end
      end
      // popcount == 1 without an adder chain
      is_last = (mask != '0) && ((mask & (mask - REG_NUM'(1))) == '0);
   end

endmodule

// File: rtl/align_p2s.sv
// Parallel-to-serial lane unpacker: two word slots (ACTIVE/PEND), enabled lanes emitted lowest first.
module align_p2s
   import align_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [GBUS_DATA-1:0] idata,
   input  logic [REG_NUM-1:0]   idata_bmask,
   input  logic                 idata_valid,
   output logic                 idata_ready,
   output logic [IDATA_BIT-1:0] odata,
   output logic                 odata_valid,
   output logic                 odata_last,
   input  logic                 odata_ready
);

   align_state_t         state, nxt_state;
   logic [GBUS_DATA-1:0] act_data, nxt_act_data, pnd_data, nxt_pnd_data;
   logic [REG_NUM-1:0]   act_mask, nxt_act_mask, pnd_mask, nxt_pnd_mask;
   logic [REG_NUM-1:0]   act_clr, act_left;
   logic [LANE_BIT-1:0]  nxt_idx;
   logic [REG_NUM-1:0]   nxt_clr;
   logic                 nxt_last;
   logic [IDATA_BIT-1:0] nxt_odata;
   logic                 load, consume, done;

   // Zero-mask words complete the handshake but never occupy a slot
   assign load     = idata_valid && idata_ready && (idata_bmask != '0);
   assign consume  = odata_valid && odata_ready;
   assign done     = consume && odata_last;
   assign act_left = consume ? (act_mask & ~act_clr) : act_mask;

   always_comb begin
      nxt_state    = state;
      nxt_act_data = act_data;
      nxt_act_mask = act_left;
      nxt_pnd_data = pnd_data;
      nxt_pnd_mask = pnd_mask;
      case (state)
         IDLE: begin
            if (load) begin
               nxt_act_data = idata;
               nxt_act_mask = idata_bmask;
               nxt_state    = BUSY;
            end
         end
         BUSY: begin
            if (done) begin
               if (load) begin
                  nxt_act_data = idata;
                  nxt_act_mask = idata_bmask;
               end else begin
                  nxt_state = IDLE;
               end
            end else if (load) begin
               nxt_pnd_data = idata;
               nxt_pnd_mask = idata_bmask;
               nxt_state    = BUSY_PEND;
            end
         end
         BUSY_PEND: begin
            if (done) begin
               nxt_act_data = pnd_data;
               nxt_act_mask = pnd_mask;
               nxt_pnd_mask = '0;
               nxt_state    = BUSY;
            end
         end
         default: begin
            nxt_act_mask = '0;
            nxt_pnd_mask = '0;
            nxt_state    = IDLE;
         end
      endcase
   end

   // Select from the next ACTIVE slot so every output leaves a flop
   p2s_lane_sel u_lane_sel (
      .mask    (nxt_act_mask),
      .idx     (nxt_idx),
      .clr     (nxt_clr),
      .is_last (nxt_last)
   );

   always_comb begin
      nxt_odata = '0;
      for (int unsigned i = 0; i < REG_NUM; i++) begin
         if ((nxt_act_mask != '0) && (nxt_idx == LANE_BIT'(i)))
            nxt_odata = nxt_act_data[i*IDATA_BIT +: IDATA_BIT];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         act_data    <= '0;
         act_mask    <= '0;
         pnd_data    <= '0;
         pnd_mask    <= '0;
         act_clr     <= '0;
         odata       <= '0;
         odata_valid <= 1'b0;
         odata_last  <= 1'b0;
         idata_ready <= 1'b1;
      end else begin
         state       <= nxt_state;
         act_data    <= nxt_act_data;
         act_mask    <= nxt_act_mask;
         pnd_data    <= nxt_pnd_data;
         pnd_mask    <= nxt_pnd_mask;
         act_clr     <= nxt_clr;
         odata       <= nxt_odata;
         odata_valid <= (nxt_act_mask != '0);
         odata_last  <= nxt_last;
         idata_ready <= (nxt_state != BUSY_PEND);
      end
   end

endmodule

// File: tb/tb_align_p2s.sv
// Self-checking bench for align_p2s: directed scenarios plus a randomized run against a lane-queue model.
module tb_align_p2s;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] idata;
   logic [7:0]  idata_bmask;
   logic        idata_valid;
   logic        idata_ready;
   logic [7:0]  odata;
   logic        odata_valid;
   logic        odata_last;
   logic        odata_ready;

   int checks = 0;
   int errors = 0;

   align_p2s dut (
      .clk         (clk),
      .rst         (rst),
      .idata       (idata),
      .idata_bmask (idata_bmask),
      .idata_valid (idata_valid),
      .idata_ready (idata_ready),
      .odata       (odata),
      .odata_valid (odata_valid),
      .odata_last  (odata_last),
      .odata_ready (odata_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] lane_of(input logic [63:0] w, input int n);
      return w[n*8 +: 8];
   endfunction

   // Reference model: pending output lanes in order, plus remaining-lane count per held word
   logic   mon_en = 1'b0;
   byte    m_data[$];
   bit     m_last[$];
   int     m_words[$];
   logic   exp_v, exp_r;

   always @(negedge clk) begin
      if (mon_en) begin
         exp_v = (m_words.size() != 0);
         exp_r = (m_words.size() < 2);
         checks++;
         if (odata_valid !== exp_v) begin
            errors++;
            $display("FAIL rand_valid t=%0t got %b want %b", $time, odata_valid, exp_v);
         end
         checks++;
         if (idata_ready !== exp_r) begin
            errors++;
            $display("FAIL rand_ready t=%0t got %b want %b", $time, idata_ready, exp_r);
         end
         if (exp_v) begin
            checks++;
            if (odata !== 8'(m_data[0]) || odata_last !== m_last[0]) begin
               errors++;
               $display("FAIL rand_lane t=%0t got %h/%b want %h/%b", $time, odata, odata_last,
                        8'(m_data[0]), m_last[0]);
            end
         end
         if (rst) begin
            m_data.delete();
            m_last.delete();
            m_words.delete();
         end else begin
            if (exp_v && odata_ready) begin
               void'(m_data.pop_front());
               void'(m_last.pop_front());
               m_words[0] = m_words[0] - 1;
               if (m_words[0] == 0) void'(m_words.pop_front());
            end
            if (idata_valid && exp_r && idata_bmask != 8'h00) begin
               int cnt;
               int seen;
               cnt  = $countones(idata_bmask);
               seen = 0;
               for (int i = 0; i < 8; i++) begin
                  if (idata_bmask[i]) begin
                     seen++;
                     m_data.push_back(byte'(lane_of(idata, i)));
                     m_last.push_back(seen == cnt);
                  end
               end
               m_words.push_back(cnt);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; idata = '0; idata_bmask = '0; idata_valid = 1'b0; odata_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++;
      if (odata_valid !== 1'b0 || odata_last !== 1'b0 || odata !== 8'h00) begin
         errors++;
         $display("FAIL reset_out got v=%b l=%b d=%h want 0/0/00", odata_valid, odata_last, odata);
      end
      checks++;
      if (idata_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b want 1", idata_ready);
      end
   endtask

   task automatic test_full_word();
      idata = 64'h0807060504030201; idata_bmask = 8'hFF; idata_valid = 1'b1; odata_ready = 1'b1;
      tick();
      idata_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (odata_valid !== 1'b1 || odata !== 8'(i + 1) || odata_last !== (i == 7)) begin
            errors++;
            $display("FAIL full_lane%0d got v=%b d=%h l=%b want 1/%h/%b", i, odata_valid, odata,
                     odata_last, 8'(i + 1), (i == 7));
         end
         tick();
      end
      checks++;
      if (odata_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_end got v=%b want 0", odata_valid);
      end
   endtask

   task automatic test_sparse_mask();
      logic [7:0] exp_b[3];
      exp_b = '{8'h03, 8'h06, 8'h08};
      idata = 64'h0807060504030201; idata_bmask = 8'b1010_0100; idata_valid = 1'b1;
      tick();
      idata_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (odata_valid !== 1'b1 || odata !== exp_b[i] || odata_last !== (i == 2)) begin
            errors++;
            $display("FAIL sparse_lane%0d got v=%b d=%h l=%b want 1/%h/%b", i, odata_valid, odata,
                     odata_last, exp_b[i], (i == 2));
         end
         tick();
      end
      idata_bmask = 8'h00; idata_valid = 1'b1;
      checks++;
      if (idata_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_accept got ready=%b want 1", idata_ready);
      end
      tick();
      idata_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (odata_valid !== 1'b0 || idata_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_drop%0d got v=%b r=%b want 0/1", i, odata_valid, idata_ready);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] wd[3];
      logic [63:0] cur;
      logic        acc, rdy_exp;
      int          sent;
      for (int k = 0; k < 3; k++) wd[k] = {$urandom, $urandom};
      sent = 0;
      idata = wd[0]; idata_bmask = 8'hFF; idata_valid = 1'b1; odata_ready = 1'b1;
      for (int e = 0; e <= 24; e++) begin
         acc = idata_valid && idata_ready;
         tick();
         if (acc) begin
            sent++;
            if (sent < 3) idata = wd[sent];
            else idata_valid = 1'b0;
         end
         rdy_exp = !((e >= 1 && e <= 7) || (e >= 9 && e <= 15));
         checks++;
         if (idata_ready !== rdy_exp) begin
            errors++;
            $display("FAIL b2b_ready e=%0d got %b want %b", e, idata_ready, rdy_exp);
         end
         checks++;
         if (e < 24) begin
            cur = wd[e / 8];
            if (odata_valid !== 1'b1 || odata !== lane_of(cur, e % 8) || odata_last !== ((e % 8) == 7)) begin
               errors++;
               $display("FAIL b2b_lane e=%0d got v=%b d=%h l=%b want 1/%h/%b", e, odata_valid, odata,
                        odata_last, lane_of(cur, e % 8), ((e % 8) == 7));
            end
         end else if (odata_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got v=%b want 0", odata_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] w;
      logic        rdy, prev_stall;
      logic [7:0]  prev_d;
      logic        prev_l;
      int          n;
      w = {$urandom, $urandom};
      idata = w; idata_bmask = 8'hFF; idata_valid = 1'b1; odata_ready = 1'b1;
      tick();
      idata_valid = 1'b0;
      n = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (prev_stall) begin
            checks++;
            if (odata_valid !== 1'b1 || odata !== prev_d || odata_last !== prev_l) begin
               errors++;
               $display("FAIL bp_stall c=%0d got v=%b d=%h l=%b want 1/%h/%b", c, odata_valid, odata,
                        odata_last, prev_d, prev_l);
            end
         end
         rdy = !(c == 2 || c == 3);
         odata_ready = rdy;
         if (odata_valid && rdy) begin
            checks++;
            if (n >= 8 || odata !== lane_of(w, n) || odata_last !== (n == 7)) begin
               errors++;
               $display("FAIL bp_lane n=%0d got d=%h l=%b want %h/%b", n, odata, odata_last,
                        lane_of(w, n % 8), (n == 7));
            end
            n++;
         end
         prev_stall = odata_valid && !rdy;
         prev_d = odata;
         prev_l = odata_last;
         tick();
      end
      odata_ready = 1'b1;
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL bp_count got %0d want 8", n);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] a, b, c;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
      idata = a; idata_bmask = 8'hFF; idata_valid = 1'b1; odata_ready = 1'b1;
      tick();
      idata = b;
      tick();
      idata_valid = 1'b0;
      tick(); tick();
      checks++;
      if (odata !== lane_of(a, 3) || idata_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_pre got d=%h r=%b want %h/0", odata, idata_ready, lane_of(a, 3));
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (odata_valid !== 1'b0 || idata_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_post got v=%b r=%b want 0/1", odata_valid, idata_ready);
      end
      idata = c; idata_bmask = 8'hFF; idata_valid = 1'b1;
      tick();
      idata_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (odata_valid !== 1'b1 || odata !== lane_of(c, i)) begin
            errors++;
            $display("FAIL rstmid_new%0d got v=%b d=%h want 1/%h", i, odata_valid, odata, lane_of(c, i));
         end
         tick();
      end
      checks++;
      if (odata_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_flush got v=%b want 0", odata_valid);
      end
   endtask

   task automatic test_simultaneous();
      idata = {$urandom, $urandom}; idata_bmask = 8'h01; idata_valid = 1'b1; odata_ready = 1'b1;
      tick();
      idata = {$urandom, 24'($urandom), 8'hAA}; idata_bmask = 8'h01;
      checks++;
      if (idata_ready !== 1'b1 || odata_last !== 1'b1 || odata_valid !== 1'b1) begin
         errors++;
         $display("FAIL simul_pre got r=%b l=%b v=%b want 1/1/1", idata_ready, odata_last, odata_valid);
      end
      tick();
      idata_valid = 1'b0;
      checks++;
      if (odata_valid !== 1'b1 || odata !== 8'hAA || odata_last !== 1'b1) begin
         errors++;
         $display("FAIL simul_next got v=%b d=%h l=%b want 1/aa/1", odata_valid, odata, odata_last);
      end
      tick();
      checks++;
      if (odata_valid !== 1'b0) begin
         errors++;
         $display("FAIL simul_end got v=%b want 0", odata_valid);
      end
   endtask

   task automatic test_random();
      m_data.delete(); m_last.delete(); m_words.delete();
      mon_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rst         = ($urandom_range(0, 299) == 0);
         idata       = {$urandom, $urandom};
         idata_bmask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         idata_valid = ($urandom_range(0, 2) != 0);
         odata_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst = 1'b0; idata_valid = 1'b0; odata_ready = 1'b1;
      repeat (24) tick();
      mon_en = 1'b0;
      checks++;
      if (m_words.size() != 0 || odata_valid !== 1'b0) begin
         errors++;
         $display("FAIL rand_drain got words=%0d v=%b want 0/0", m_words.size(), odata_valid);
      end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_sparse_mask();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_simultaneous();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/align_p2s.md
# align_p2s

Parallel-to-serial lane unpacker: accepts a GBUS-width word with a per-lane byte mask and emits the enabled IDATA_BIT lanes one per cycle, lowest lane first, under a valid/ready handshake. It is the inverse of the core's output serial-to-parallel packer. It sits between the GBUS/vector-engine return path and per-core byte-serial consumers, such as the quantised-activation write path into the activation buffer. It also closes the partial-word gap by supporting a byte mask on the final transfer.

## Interface
- IDATA_BIT, 8: output lane width.
- GBUS_DATA, 64: input word width; must be an integer multiple of IDATA_BIT.
- REG_NUM, GBUS_DATA/IDATA_BIT (derived, localparam): lanes per word.
- LANE_BIT, $clog2(REG_NUM) (derived, localparam): lane index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- idata  input  GBUS_DATA  packed word; lane i = idata[i*IDATA_BIT +: IDATA_BIT].
- idata_bmask  input  REG_NUM  lane enable; bit i qualifies lane i.
- idata_valid  input  1  word present.
- idata_ready  output  1  block can take a word.
- odata  output  IDATA_BIT  current lane.
- odata_valid  output  1  odata valid.
- odata_last  output  1  odata is the last enabled lane of its word.
- odata_ready  input  1  consumer takes odata.

## Operation
- Input handshake: a word is accepted when idata_valid && idata_ready.
- Output handshake: a lane is consumed when odata_valid && odata_ready.
- Storage is two word slots, ACTIVE and PEND, each holding data plus a remaining-lane mask.
- FSM states:
  - IDLE: no words held.
  - BUSY: ACTIVE held.
  - BUSY_PEND: ACTIVE and PEND both held.
- idata_ready = (state != BUSY_PEND). It is registered-state-derived and has no combinational path from odata_ready.
- Zero-mask words are accepted and dropped. They never enter a slot and the state does not change.
- Lane order: the lowest set bit of ACTIVE's remaining mask is presented. On consume, that bit is cleared.
- odata_last = 1 when exactly one bit remains in ACTIVE's mask.
- Non-contiguous masks are legal; unset lanes are skipped with no bubble.
- Transitions on consume of the last lane:
  - BUSY with no accept → IDLE.
  - BUSY with a simultaneous accept → BUSY, and the new word loads directly into ACTIVE.
  - BUSY_PEND → BUSY, with PEND moving to ACTIVE.
- Transitions on accept when no last-lane consume occurs:
  - IDLE → BUSY, word loads into ACTIVE.
  - BUSY → BUSY_PEND, word loads into PEND.
- Stall rule: while odata_valid && !odata_ready, odata, odata_last and odata_valid hold stable.
- Reset: rst clears state to IDLE and clears both masks, discarding in-flight lanes.

## Timing
- Reset values:
  - odata_valid = 0, odata_last = 0, odata = 0.
  - idata_ready = 1 in the first cycle after rst deasserts.
- Latency: a word accepted at edge N has its first lane valid in cycle N+1, with outputs driven from registers only.
- Throughput: 1 lane/cycle with odata_ready held high.
  - Back-to-back full-mask words stream with no bubble between the last lane of word k and the first lane of word k+1.
  - A word with k enabled lanes occupies the output for exactly k cycles.
- A last-lane consume and an accept in the same cycle in BUSY is legal: the next cycle shows the new word's lowest enabled lane.
- rst asserted mid-stream: odata_valid = 0 and idata_ready = 1 from the next cycle.

## Structure
- Shared package `align_pkg`:
  - IDATA_BIT and GBUS_DATA defaults.
  - REG_NUM derivation.
  - FSM state typedef (IDLE, BUSY, BUSY_PEND).
  - Shared with the serial-to-parallel packer.
- Sub-module `p2s_lane_sel`: combinational priority encoder.
  - Input: REG_NUM-bit mask.
  - Outputs: lowest set index (LANE_BIT), one-hot clear mask, and is_last (popcount == 1).
- Top level holds the two slots, the FSM and the output mux.

## Test plan
- Full word: idata=64'h0807060504030201, bmask=8'hFF, odata_ready=1 → odata 01..08 in cycles N+1..N+8; odata_last only with 08.
- Partial and sparse mask: same data, bmask=8'b1010_0100 → odata 03, 06, 08 on consecutive cycles; last with 08. Then bmask=8'h00 → accepted, no output, idata_ready stays 1.
- Back-to-back streaming: three full words with idata_valid held → 24 consecutive valid cycles with no gap. idata_ready deasserts while PEND is full and reasserts the cycle PEND drains.
- Backpressure: odata_ready toggled 1,0,0,1 mid-word → odata and odata_last stable during stall, no lane lost or duplicated, order preserved.
- Reset mid-stream: rst pulsed after 3 lanes of a full word with a word in PEND → next cycle odata_valid=0 and idata_ready=1. A new word afterwards starts at its lane 0.
- Simultaneous edge: in BUSY, consume the last lane in the same cycle a new word (bmask=8'h01, data byte AA) is accepted → next cycle odata=AA with odata_last=1.
